qbert_jump_ctrl: RTL and testbench
==================================

// Module: qbert_jump_ctrl
// PURPOSE
// Upstream controller for the Q*bert sprite layer on the 28-cube pyramid.
// Turns direction requests from the Nios/joystick into the sprite layer's jump inputs:
// e_jump_qb, position_qb, e_next_qb and e_bad_jump.
// Tracks Q*bert's pyramid cell, commits moves on the layer's done_move, and keeps the visited-cube map and level-clear flag.
// PARAMETERS
// N_ROW   7   pyramid rows; cube k of row r (r=1..N_ROW, p=0..r-1) has index r(r-1)/2+p
// N_CUBE  28  N_ROW*(N_ROW+1)/2; width of the one-hot cube vectors
// PORTS
// clk          in   1       system clock
// reset        in   1       synchronous, active-high
// dir_valid    in   1       1-cycle strobe: new direction request
// dir_code     in   3       1 DOWN_RIGHT, 2 DOWN_LEFT, 3 UP_RIGHT, 4 UP_LEFT; other values are ignored
// restart      in   1       1-cycle strobe, same as the game start pulse: clears visited map
// state_qb     in   3       layer state: 0 START, 1 JUMP, 2 IDLE, 3 SAUCER, 4 KO
// done_move    in   1       layer move-complete level
// position_qb  out  N_CUBE  one-hot current cube (bit0 = top)
// e_next_qb    out  N_CUBE  one-hot target cube; all-zero when off-pyramid
// e_jump_qb    out  3       direction of the last accepted jump; held, not cleared
// e_bad_jump   out  1       high while the pending jump leaves the pyramid
// visited      out  N_CUBE  cubes landed on since restart
// cube_cnt     out  5       popcount of visited
// level_clear  out  1       high when cube_cnt == N_CUBE
// busy         out  1       high in any state except READY
// BEHAVIOUR
// - Reset and restart values:
//   - Reset: row=1, p=0, position_qb=e_next_qb=1, visited=1, cube_cnt=1; all other outputs 0; FSM in READY.
//   - restart: same values as reset, except e_jump_qb is held.
// - Geometry: p=0 is the right edge (cubes 1,2,4,7,11,16,22); p=r-1 is the left edge.
//   - DOWN_RIGHT → (r+1,p).
//   - DOWN_LEFT → (r+1,p+1).
//   - UP_RIGHT → (r-1,p-1); bad if p==0.
//   - UP_LEFT → (r-1,p); bad if p==r-1.
//   - Down from r==N_ROW is bad.
// - FSM states: READY, ARMED, MOVING, WAIT_START.
//   - READY: accept dir_valid with a legal code only when state_qb==IDLE. Next cycle:
//     - e_jump_qb=dir_code;
//     - e_next_qb=target one-hot, or 0 if bad;
//     - e_bad_jump set accordingly;
//     - go to ARMED.
//     - Requests in any other state are dropped; there is no queue.
//   - ARMED: wait for state_qb==JUMP, then go to MOVING.
//     - If state_qb==SAUCER or START is seen first, go to WAIT_START.
//   - MOVING: on the rising edge of done_move (registered compare) with state_qb leaving JUMP:
//     - Good jump: commit row/p. position_qb=e_next_qb; set the visited bit; increment cube_cnt if the bit was new. Go to READY.
//     - Bad jump: go to WAIT_START; e_bad_jump stays high.
//   - WAIT_START: on state_qb==START, move to the top cell (position_qb=e_next_qb=1) and clear e_bad_jump. Go to READY once state_qb==IDLE.
// - Invariant: in READY, e_next_qb == position_qb. This blocks the layer from re-jumping while e_jump_qb is held.
// - The layer enters START from IDLE via the saucer (SAUCER→START). In any state, state_qb==START forces the top cell.
// - Priority when events coincide in one cycle: reset > restart > START-force > FSM transition.
//   - restart with a commit: the visited map becomes top-only; position still commits.
// - Arithmetic: the index r(r-1)/2+p uses a constant row-base table, not a multiplier; one-hot = 1<<index.
//   - cube_cnt saturates at N_CUBE.
//   - level_clear is registered, one cycle after cube_cnt reaches N_CUBE.
// STRUCTURE
// - qbert_pkg: dir_t codes (DOWN_RIGHT..UP_LEFT); qstate_t encoding matching state_qb; N_ROW/N_CUBE; row-base table.
// - Sub-module qbert_pyr_nav: combinational. (row,p,dir) → (row',p', bad, onehot). Shared later with the enemy movers.
// - Top level holds the FSM, the position registers, the visited register and the counter.
// TESTING
// 1. Reset, then state_qb=IDLE, dir 1 → e_next_qb=0x2, e_bad_jump=0. Then JUMP, done_move↑, IDLE → position_qb=0x2, cube_cnt=2.
// 2. From top, dir 3 → e_next_qb=0, e_bad_jump=1. After KO then START → position_qb=0x1, e_bad_jump=0, busy falls at IDLE.
// 3. Six DOWN_RIGHT commits → position_qb=0x200000 (cube 22). Then dir 1 → bad jump flagged.
// 4. dir_valid while state_qb=JUMP → ignored: e_next_qb and e_jump_qb unchanged, no new ARMED.
// 5. Cover all 28 cubes, revisiting cube 5 twice → cube_cnt=28 (no double count), level_clear=1 the next cycle. restart → visited=0x1, cube_cnt=1.
// 6. Reset asserted in MOVING → all outputs at reset values the next cycle; a later done_move↑ causes no commit.

Source files
------------

// File: rtl/qbert_pkg.sv
// Shared Q*bert pyramid definitions: direction codes, sprite-layer state
// encoding, pyramid size and the row-base table used for cube indexing.
package qbert_pkg;

   localparam int N_ROW  = 7;
   localparam int N_CUBE = N_ROW * (N_ROW + 1) / 2;

   localparam logic [4:0]        CNT_FULL = 5'(N_CUBE);
   localparam logic [N_CUBE-1:0] TOP_CUBE = N_CUBE'(1);

   typedef enum logic [2:0] {
      DIR_NONE   = 3'd0,
      DOWN_RIGHT = 3'd1,
      DOWN_LEFT  = 3'd2,
      UP_RIGHT   = 3'd3,
      UP_LEFT    = 3'd4
   } dir_t;

   typedef enum logic [2:0] {
      Q_START  = 3'd0,
      Q_JUMP   = 3'd1,
      Q_IDLE   = 3'd2,
      Q_SAUCER = 3'd3,
      Q_KO     = 3'd4
   } qstate_t;

   localparam logic [1:0] ST_READY      = 2'd0;
   localparam logic [1:0] ST_ARMED      = 2'd1;
   localparam logic [1:0] ST_MOVING     = 2'd2;
   localparam logic [1:0] ST_WAIT_START = 2'd3;

   // Index of cube (r,0): r(r-1)/2, tabulated so no multiplier is built.
   function automatic logic [4:0] row_base(input logic [2:0] r);
      case (r)
         3'd1:    row_base = 5'd0;
         3'd2:    row_base = 5'd1;
         3'd3:    row_base = 5'd3;
         3'd4:    row_base = 5'd6;
         3'd5:    row_base = 5'd10;
         3'd6:    row_base = 5'd15;
         3'd7:    row_base = 5'd21;
         default: row_base = 5'd0;
      endcase
   endfunction

   function automatic logic dir_legal(input logic [2:0] d);
      dir_legal = (d >= 3'd1) && (d <= 3'd4);
   endfunction

endpackage

// File: rtl/qbert_pyr_nav.sv
// Combinational pyramid navigator: one jump from (row,p) in direction dir,
// giving the target cell, an off-pyramid flag and the target one-hot.
module qbert_pyr_nav
   import qbert_pkg::*;
(
   input  logic [2:0]        row,
   input  logic [2:0]        p,
   input  logic [2:0]        dir,
   output logic [2:0]        row_next,
   output logic [2:0]        p_next,
   output logic              bad,
   output logic [N_CUBE-1:0] onehot
);

   logic [4:0] index;

   always_comb begin
      row_next = row;
      p_next   = p;
      bad      = 1'b1;
      case (dir)
         DOWN_RIGHT: begin
            row_next = row + 3'd1;
            bad      = (row == 3'(N_ROW));
         end
         DOWN_LEFT: begin
            row_next = row + 3'd1;
            p_next   = p + 3'd1;
            bad      = (row == 3'(N_ROW));
         end
         UP_RIGHT: begin
            row_next = row - 3'd1;
            p_next   = p - 3'd1;
            bad      = (p == 3'd0);
         end
         UP_LEFT: begin
            row_next = row - 3'd1;
            bad      = (p == row - 3'd1);
         end
         default: bad = 1'b1;
      endcase
   end

   assign index  = row_base(row_next) + {2'b00, p_next};
   assign onehot = bad ? '0 : (TOP_CUBE << index);

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert jump controller: turns direction requests into sprite-layer jump
// inputs, tracks the current cube, and keeps the visited map and level flag.
module qbert_jump_ctrl
   import qbert_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              dir_valid,
   input  logic [2:0]        dir_code,
   input  logic              restart,
   input  logic [2:0]        state_qb,
   input  logic              done_move,
   output logic [N_CUBE-1:0] position_qb,
   output logic [N_CUBE-1:0] e_next_qb,
   output logic [2:0]        e_jump_qb,
   output logic              e_bad_jump,
   output logic [N_CUBE-1:0] visited,
   output logic [4:0]        cube_cnt,
   output logic              level_clear,
   output logic              busy,
   output logic [1:0]        fsm_state
);

   // Handshake: dir_valid is a one-cycle strobe with no ready; it is taken only
   // in READY while the layer reports IDLE, otherwise it is dropped.
   logic [1:0]        state;
   logic [2:0]        cur_row, cur_p;
   logic [2:0]        pend_row, pend_p;
   logic              done_prev;
   logic              done_rise;
   logic              commit_good;
   logic              cube_new;
   logic [2:0]        nav_row, nav_p;
   logic              nav_bad;
   logic [N_CUBE-1:0] nav_onehot;

   qbert_pyr_nav u_nav (
      .row      (cur_row),
      .p        (cur_p),
      .dir      (dir_code),
      .row_next (nav_row),
      .p_next   (nav_p),
      .bad      (nav_bad),
      .onehot   (nav_onehot)
   );

   assign done_rise   = done_move & ~done_prev;
   assign commit_good = (state == ST_MOVING) && done_rise && !e_bad_jump;
   assign cube_new    = ((visited & e_next_qb) == '0);
   assign busy        = (state != ST_READY);
   assign fsm_state   = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_READY;
         cur_row     <= 3'd1;
         cur_p       <= 3'd0;
         pend_row    <= 3'd1;
         pend_p      <= 3'd0;
         position_qb <= TOP_CUBE;
         e_next_qb   <= TOP_CUBE;
         e_jump_qb   <= 3'd0;
         e_bad_jump  <= 1'b0;
         visited     <= TOP_CUBE;
         cube_cnt    <= 5'd1;
         level_clear <= 1'b0;
         done_prev   <= 1'b0;
      end else begin
         done_prev   <= done_move;
         level_clear <= (cube_cnt == CNT_FULL);
         if (restart) begin
            // A jump landing in the same cycle still moves Q*bert; only the map resets.
            visited     <= TOP_CUBE;
            cube_cnt    <= 5'd1;
            level_clear <= 1'b0;
            e_bad_jump  <= 1'b0;
            state       <= ST_READY;
            if (commit_good) begin
               cur_row     <= pend_row;
               cur_p       <= pend_p;
               position_qb <= e_next_qb;
            end else begin
               cur_row     <= 3'd1;
               cur_p       <= 3'd0;
               position_qb <= TOP_CUBE;
               e_next_qb   <= TOP_CUBE;
            end
         end else if (state_qb == Q_START) begin
            cur_row     <= 3'd1;
            cur_p       <= 3'd0;
            position_qb <= TOP_CUBE;
            e_next_qb   <= TOP_CUBE;
            e_bad_jump  <= 1'b0;
            state       <= ST_WAIT_START;
         end else begin
            case (state)
               ST_READY: begin
                  if (dir_valid && dir_legal(dir_code) && (state_qb == Q_IDLE)) begin
                     e_jump_qb  <= dir_code;
                     e_next_qb  <= nav_onehot;
                     e_bad_jump <= nav_bad;
                     pend_row   <= nav_row;
                     pend_p     <= nav_p;
                     state      <= ST_ARMED;
                  end
               end
               ST_ARMED: begin
                  if (state_qb == Q_JUMP)
                     state <= ST_MOVING;
                  else if (state_qb == Q_SAUCER)
                     state <= ST_WAIT_START;
               end
               ST_MOVING: begin
                  if (done_rise) begin
                     if (e_bad_jump) begin
                        state <= ST_WAIT_START;
                     end else begin
                        cur_row     <= pend_row;
                        cur_p       <= pend_p;
                        position_qb <= e_next_qb;
                        visited     <= visited | e_next_qb;
                        if (cube_new && (cube_cnt != CNT_FULL))
                           cube_cnt <= cube_cnt + 5'd1;
                        state <= ST_READY;
                     end
                  end
               end
               default: begin
                  // Leave only after START has put both vectors back on the top cube.
                  if ((state_qb == Q_IDLE) && (e_next_qb == position_qb))
                     state <= ST_READY;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Directed bench for qbert_jump_ctrl: scripted sprite-layer states and jumps
// with hand-computed cube indices and visit counts.
module tb_qbert_jump_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        dir_valid;
   logic [2:0]  dir_code;
   logic        restart;
   logic [2:0]  state_qb;
   logic        done_move;
   logic [27:0] position_qb;
   logic [27:0] e_next_qb;
   logic [2:0]  e_jump_qb;
   logic        e_bad_jump;
   logic [27:0] visited;
   logic [4:0]  cube_cnt;
   logic        level_clear;
   logic        busy;
   logic [1:0]  fsm_state;

   int errors = 0;
   int checks = 0;

   localparam logic [2:0] S_START = 3'd0, S_JUMP = 3'd1, S_IDLE = 3'd2, S_KO = 3'd4;

   // Route from the top that lands on all 28 cubes, cube 5 (row 3, p 1) three times.
   localparam int N_PATH = 34;
   logic [2:0] path [N_PATH] = '{
      3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
      3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2, 3'd4, 3'd2,
      3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
      3'd1, 3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd1,
      3'd2, 3'd4, 3'd4, 3'd2
   };

   qbert_jump_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .dir_valid   (dir_valid),
      .dir_code    (dir_code),
      .restart     (restart),
      .state_qb    (state_qb),
      .done_move   (done_move),
      .position_qb (position_qb),
      .e_next_qb   (e_next_qb),
      .e_jump_qb   (e_jump_qb),
      .e_bad_jump  (e_bad_jump),
      .visited     (visited),
      .cube_cnt    (cube_cnt),
      .level_clear (level_clear),
      .busy        (busy),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic request(input logic [2:0] d);
      state_qb  = S_IDLE;
      dir_valid = 1'b1;
      dir_code  = d;
      tick();
      dir_valid = 1'b0;
   endtask

   // Full good jump: request, layer JUMP, then done_move rises as layer returns to IDLE.
   task automatic do_jump(input logic [2:0] d);
      request(d);
      state_qb = S_JUMP;
      tick();
      done_move = 1'b1;
      state_qb  = S_IDLE;
      tick();
      done_move = 1'b0;
   endtask

   initial begin
      reset = 1'b1; dir_valid = 1'b0; dir_code = 3'd0; restart = 1'b0;
      state_qb = S_IDLE; done_move = 1'b0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_pos",     32'(position_qb), 32'h1);
      check("rst_next",    32'(e_next_qb),   32'h1);
      check("rst_visited", 32'(visited),     32'h1);
      check("rst_cnt",     32'(cube_cnt),    32'd1);
      check("rst_jump",    32'(e_jump_qb),   32'd0);
      check("rst_bad",     32'(e_bad_jump),  32'd0);
      check("rst_level",   32'(level_clear), 32'd0);
      check("rst_busy",    32'(busy),        32'd0);

      // Test 1: DOWN_RIGHT from the top lands on cube 2.
      request(3'd1);
      check("t1_next",  32'(e_next_qb),  32'h2);
      check("t1_bad",   32'(e_bad_jump), 32'd0);
      check("t1_jump",  32'(e_jump_qb),  32'd1);
      check("t1_armed", 32'(fsm_state),  32'd1);
      check("t1_pos_hold", 32'(position_qb), 32'h1);
      state_qb = S_JUMP;
      tick();
      check("t1_moving", 32'(fsm_state), 32'd2);
      done_move = 1'b1; state_qb = S_IDLE;
      tick();
      done_move = 1'b0;
      check("t1_pos",     32'(position_qb), 32'h2);
      check("t1_cnt",     32'(cube_cnt),    32'd2);
      check("t1_visited", 32'(visited),     32'h3);
      check("t1_busy",    32'(busy),        32'd0);

      // Test 4: request while the layer is still jumping is dropped.
      state_qb = S_JUMP; dir_valid = 1'b1; dir_code = 3'd2;
      tick();
      dir_valid = 1'b0;
      check("t4_next", 32'(e_next_qb), 32'h2);
      check("t4_jump", 32'(e_jump_qb), 32'd1);
      check("t4_busy", 32'(busy),      32'd0);
      tick();
      check("t4_still_ready", 32'(fsm_state), 32'd0);

      // Back to the top with UP_LEFT; revisit does not count.
      do_jump(3'd4);
      check("t2_pre_pos", 32'(position_qb), 32'h1);
      check("t2_pre_cnt", 32'(cube_cnt),    32'd2);

      // Test 2: UP_RIGHT from the top is off-pyramid; KO then START recovers.
      request(3'd3);
      check("t2_next", 32'(e_next_qb),  32'h0);
      check("t2_bad",  32'(e_bad_jump), 32'd1);
      check("t2_jump", 32'(e_jump_qb),  32'd3);
      state_qb = S_JUMP;
      tick();
      state_qb = S_KO;
      tick();
      check("t2_ko_busy", 32'(busy),       32'd1);
      check("t2_ko_bad",  32'(e_bad_jump), 32'd1);
      state_qb = S_START;
      tick();
      check("t2_start_pos",  32'(position_qb), 32'h1);
      check("t2_start_next", 32'(e_next_qb),   32'h1);
      check("t2_start_bad",  32'(e_bad_jump),  32'd0);
      check("t2_start_busy", 32'(busy),        32'd1);
      state_qb = S_IDLE;
      tick();
      check("t2_idle_busy", 32'(busy),     32'd0);
      check("t2_cnt",       32'(cube_cnt), 32'd2);

      // Test 3: six DOWN_RIGHT to cube 22, then one more is off the bottom.
      for (int i = 0; i < 6; i++) do_jump(3'd1);
      check("t3_pos", 32'(position_qb), 32'h200000);
      check("t3_cnt", 32'(cube_cnt),    32'd7);
      request(3'd1);
      check("t3_next", 32'(e_next_qb),  32'h0);
      check("t3_bad",  32'(e_bad_jump), 32'd1);
      state_qb = S_JUMP;
      tick();
      done_move = 1'b1; state_qb = S_KO;
      tick();
      done_move = 1'b0;
      check("t3_fall_busy", 32'(busy),        32'd1);
      check("t3_fall_bad",  32'(e_bad_jump),  32'd1);
      check("t3_fall_pos",  32'(position_qb), 32'h200000);
      check("t3_fall_cnt",  32'(cube_cnt),    32'd7);
      state_qb = S_START;
      tick();
      check("t3_start_pos", 32'(position_qb), 32'h1);
      check("t3_start_bad", 32'(e_bad_jump),  32'd0);
      state_qb = S_IDLE;
      tick();
      check("t3_idle_busy", 32'(busy), 32'd0);

      // Test 5: restart, then cover the whole pyramid.
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("t5_rst_visited", 32'(visited),   32'h1);
      check("t5_rst_cnt",     32'(cube_cnt),  32'd1);
      check("t5_rst_jump",    32'(e_jump_qb), 32'd1);
      for (int i = 0; i < N_PATH - 4; i++) do_jump(path[i]);
      check("t5_mid_pos", 32'(position_qb), 32'h800);
      check("t5_mid_cnt", 32'(cube_cnt),    32'd25);
      for (int i = N_PATH - 4; i < N_PATH; i++) do_jump(path[i]);
      check("t5_end_pos",     32'(position_qb), 32'h2000);
      check("t5_end_cnt",     32'(cube_cnt),    32'd28);
      check("t5_end_visited", 32'(visited),     32'hFFFFFFF);
      check("t5_level_early", 32'(level_clear), 32'd0);
      tick();
      check("t5_level", 32'(level_clear), 32'd1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("t5_clr_visited", 32'(visited),     32'h1);
      check("t5_clr_cnt",     32'(cube_cnt),    32'd1);
      check("t5_clr_pos",     32'(position_qb), 32'h1);
      check("t5_clr_level",   32'(level_clear), 32'd0);

      // Test 6: reset while MOVING; a later done_move edge must not commit.
      request(3'd1);
      state_qb = S_JUMP;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_pos",  32'(position_qb), 32'h1);
      check("t6_next", 32'(e_next_qb),   32'h1);
      check("t6_jump", 32'(e_jump_qb),   32'd0);
      check("t6_busy", 32'(busy),        32'd0);
      done_move = 1'b1; state_qb = S_IDLE;
      tick();
      done_move = 1'b0;
      check("t6_nocommit_pos", 32'(position_qb), 32'h1);
      check("t6_nocommit_cnt", 32'(cube_cnt),    32'd1);

      // Restart in the landing cycle: position commits, map goes top-only.
      request(3'd2);
      check("t7_next", 32'(e_next_qb), 32'h4);
      state_qb = S_JUMP;
      tick();
      done_move = 1'b1; state_qb = S_IDLE; restart = 1'b1;
      tick();
      done_move = 1'b0; restart = 1'b0;
      check("t7_pos",     32'(position_qb), 32'h4);
      check("t7_visited", 32'(visited),     32'h1);
      check("t7_cnt",     32'(cube_cnt),    32'd1);
      check("t7_busy",    32'(busy),        32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
